// File: rtl/io_irq_port.sv
`default_nettype none
// ============================================================================
//  Module      : io_irq_port
//  Description : Memory-mapped interrupt/IO responder for the cpu65CE02 bus.
//                Four-byte window holding a software IRQ/NMI port register
//                and a 16-bit auto-reload interval timer with pending flag.
//                Read data is registered so it lines up with the CPU's
//                registered address and is selected with sel.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_irq_port #(
    parameter logic [15:0] BASE = 16'hBFFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic [15:0] address_next,
    input  logic        write_next,
    input  logic [7:0]  data_i,
    output logic [7:0]  data_o,
    output logic        sel,
    output logic        irq,
    output logic        nmi
);

    localparam logic [1:0] C_OFF_PORT = 2'd0;
    localparam logic [1:0] C_OFF_CTRL = 2'd1;
    localparam logic [1:0] C_OFF_TLO  = 2'd2;
    localparam logic [1:0] C_OFF_THI  = 2'd3;

    logic        w_hit;
    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic        w_wr_port;
    logic        w_wr_ctrl;
    logic        w_wr_tlo;
    logic        w_wr_thi;
    logic        w_expire;
    logic [7:0]  w_rdata;

    logic [7:0]  r_port;
    logic        r_run;
    logic        r_ten;
    logic        r_pend;
    logic [7:0]  r_rel_lo;
    logic [7:0]  r_rel_hi;
    logic [15:0] r_cnt;
    logic [7:0]  r_snap;
    logic [7:0]  r_data_o;
    logic        r_sel;

    // Bus decode of the CPU's next-cycle signals and timer expiry condition
    always_comb begin
        w_hit     = (address_next[15:2] == BASE[15:2]);
        w_off     = address_next[1:0];
        w_wr      = w_hit & write_next & ready;
        w_rd      = w_hit & ~write_next & ready;
        w_wr_port = w_wr & (w_off == C_OFF_PORT);
        w_wr_ctrl = w_wr & (w_off == C_OFF_CTRL);
        w_wr_tlo  = w_wr & (w_off == C_OFF_TLO);
        w_wr_thi  = w_wr & (w_off == C_OFF_THI);
        w_expire  = r_run & (r_cnt == 16'd0);
    end

    // Read mux over pre-edge register state
    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            C_OFF_PORT: w_rdata = r_port;
            C_OFF_CTRL: w_rdata = {r_pend, 5'b00000, r_ten, r_run};
            C_OFF_TLO:  w_rdata = r_cnt[7:0];
            C_OFF_THI:  w_rdata = r_snap;
            default:    w_rdata = 8'h00;
        endcase
    end

    // Software-writable port and control bits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_port <= 8'h00;
            r_run  <= 1'b0;
            r_ten  <= 1'b0;
        end else begin
            if (w_wr_port) begin
                r_port <= data_i;
            end
            if (w_wr_ctrl) begin
                r_run <= data_i[0];
                r_ten <= data_i[1];
            end
        end
    end

    // Interval timer: reload values, counter and pending flag.
    // A THI write overrides an expiry on the same edge; an expiry overrides
    // a clear-pending write on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rel_lo <= 8'h00;
            r_rel_hi <= 8'h00;
            r_cnt    <= 16'h0000;
            r_pend   <= 1'b0;
        end else begin
            if (w_wr_tlo) begin
                r_rel_lo <= data_i;
            end
            if (w_wr_thi) begin
                r_rel_hi <= data_i;
                r_cnt    <= {data_i, r_rel_lo};
                r_pend   <= 1'b0;
            end else if (w_expire) begin
                r_cnt    <= {r_rel_hi, r_rel_lo};
                r_pend   <= 1'b1;
            end else begin
                if (r_run) begin
                    r_cnt <= r_cnt - 16'd1;
                end
                if (w_wr_ctrl && data_i[7]) begin
                    r_pend <= 1'b0;
                end
            end
        end
    end

    // Registered read data, high-byte snapshot and window select
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data_o <= 8'h00;
            r_snap   <= 8'h00;
            r_sel    <= 1'b0;
        end else begin
            r_sel <= w_hit & ready;
            if (w_rd) begin
                r_data_o <= w_rdata;
                if (w_off == C_OFF_TLO) begin
                    r_snap <= r_cnt[15:8];
                end
            end
        end
    end

    assign data_o = r_data_o;
    assign sel    = r_sel;
    assign irq    = r_port[0] | (r_pend & r_ten);
    assign nmi    = r_port[1];

endmodule
`default_nettype wire
